// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter mapping NUM_CORES request channels onto the A/B ports of a
// dual-port word memory, with same-word write conflict avoidance and 1-cycle responses.
module shared_mem_arbiter #(
    parameter int XLEN      = 32,
    parameter int NUM_CORES = 4,
    parameter int MEM_SIZE  = 16384
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      req_valid,
    input  logic [NUM_CORES-1:0]      req_we,
    input  logic [NUM_CORES*XLEN-1:0] req_addr,
    input  logic [NUM_CORES*XLEN-1:0] req_wdata,
    output logic [NUM_CORES-1:0]      req_ready,
    output logic [NUM_CORES-1:0]      rsp_valid,
    output logic [NUM_CORES*XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0]           mem_addr_a,
    output logic                      mem_we_a,
    output logic [XLEN-1:0]           mem_wdata_a,
    input  logic [XLEN-1:0]           mem_rdata_a,
    output logic [XLEN-1:0]           mem_addr_b,
    output logic                      mem_we_b,
    output logic [XLEN-1:0]           mem_wdata_b,
    input  logic [XLEN-1:0]           mem_rdata_b
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int IW = $clog2(NUM_CORES);

    // Handshake: a request transfers in any cycle where req_valid & req_ready are both
    // high; a core that sees req_ready low must hold valid/we/addr/wdata stable.

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_ptr_next;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   w0;
    logic [IW-1:0]   w1;
    logic            found0;
    logic            found1;
    logic [XLEN-1:0] addr0;
    logic [XLEN-1:0] addr1;
    logic            conflict;
    logic            grant_a;
    logic            grant_b;

    logic            pa_valid;
    logic [IW-1:0]   pa_id;
    logic            pa_we;
    logic            pb_valid;
    logic [IW-1:0]   pb_id;
    logic            pb_we;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_CORES - 1) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        found0   = 1'b0;
        found1   = 1'b0;
        w0       = '0;
        w1       = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = IW'((int'(rr_ptr) + k) % NUM_CORES);
            if (req_valid[scan_idx]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    w0     = scan_idx;
                end else if (!found1) begin
                    found1 = 1'b1;
                    w1     = scan_idx;
                end
            end
        end
    end

    assign addr0 = req_addr[w0*XLEN +: XLEN];
    assign addr1 = req_addr[w1*XLEN +: XLEN];

    // Compare only the bits the memory decodes so aliased addresses still conflict.
    assign conflict = found1 && (addr0[AW-1:0] == addr1[AW-1:0]) && (req_we[w0] || req_we[w1]);
    assign grant_a  = found0 && !rst;
    assign grant_b  = found1 && !conflict && !rst;

    always_comb begin
        req_ready = '0;
        if (grant_a) req_ready = req_ready | (NUM_CORES'(1) << w0);
        if (grant_b) req_ready = req_ready | (NUM_CORES'(1) << w1);
    end

    assign mem_addr_a  = grant_a ? addr0 : '0;
    assign mem_we_a    = grant_a ? req_we[w0] : 1'b0;
    assign mem_wdata_a = grant_a ? req_wdata[w0*XLEN +: XLEN] : '0;
    assign mem_addr_b  = grant_b ? addr1 : '0;
    assign mem_we_b    = grant_b ? req_we[w1] : 1'b0;
    assign mem_wdata_b = grant_b ? req_wdata[w1*XLEN +: XLEN] : '0;

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_b)      rr_ptr_next = wrap_inc(w1);
        else if (grant_a) rr_ptr_next = wrap_inc(w0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            pa_valid <= 1'b0;
            pa_id    <= '0;
            pa_we    <= 1'b0;
            pb_valid <= 1'b0;
            pb_id    <= '0;
            pb_we    <= 1'b0;
        end else begin
            rr_ptr   <= rr_ptr_next;
            pa_valid <= grant_a;
            pa_id    <= w0;
            pa_we    <= mem_we_a;
            pb_valid <= grant_b;
            pb_id    <= w1;
            pb_we    <= mem_we_b;
        end
    end

    // Port A and B always serve different cores, so the two slices never overlap.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pa_valid && !rst) begin
            rsp_valid[pa_id] = 1'b1;
            if (!pa_we) rsp_rdata[pa_id*XLEN +: XLEN] = mem_rdata_a;
        end
        if (pb_valid && !rst) begin
            rsp_valid[pb_id] = 1'b1;
            if (!pb_we) rsp_rdata[pb_id*XLEN +: XLEN] = mem_rdata_b;
        end
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter that multiplexes NUM_CORES core request channels onto the two ports (A, B) of the dual-port shared word memory.
- Grants up to two requests per cycle.
- Prevents same-word port collisions involving a write.
- Returns read data with a fixed one-cycle latency to the requester.
- Sits between the core load/store units and the shared memory in the multi-core top.

Parameters:
- XLEN, 32, data and address width.
- NUM_CORES, 4, number of requesters; legal range 2..16.
- MEM_SIZE, 16384, memory depth in words; AW = $clog2(MEM_SIZE) low address bits are significant.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_CORES  per-core request valid.
- req_we  input  NUM_CORES  per-core write enable (1 = write).
- req_addr  input  NUM_CORES*XLEN  per-core word address; core i uses slice [i*XLEN +: XLEN].
- req_wdata  input  NUM_CORES*XLEN  per-core write data.
- req_ready  output  NUM_CORES  grant; the request is accepted in any cycle where valid & ready.
- rsp_valid  output  NUM_CORES  one-cycle response pulse (read data or write ack).
- rsp_rdata  output  NUM_CORES*XLEN  read data, valid when rsp_valid is high.
- mem_addr_a / mem_addr_b  output  XLEN  port address.
- mem_we_a / mem_we_b  output  1  port write enable.
- mem_wdata_a / mem_wdata_b  output  XLEN  write data; the top drives the memory's bidirectional data pin from this signal when we = 1.
- mem_rdata_a / mem_rdata_b  input  XLEN  port read data; the memory's registered output, valid one cycle after the address is presented.

Behaviour:
- State: rr_ptr, range 0..NUM_CORES-1.
- Response pipeline register, one entry per port: valid, core id, we.
- Arbitration is combinational each cycle.
  - Scan cores in order rr_ptr, rr_ptr+1, ... (mod NUM_CORES).
  - First core with req_valid = winner W0 → port A.
  - Next core with req_valid = candidate W1 → port B.
- Conflict rule: if addr[AW-1:0] of W0 equals that of W1 and either is a write, W1 is not granted this cycle. Port B stays idle; the scan does not continue past W1.
  - Read/read to the same word is allowed on both ports.
- req_ready is high only for W0 and the granted W1. Every other core sees 0 and must hold its request stable.
- Unused port: addr = 0, we = 0, wdata = 0.
- Granted port: drives mem_addr, mem_we and mem_wdata from the winner's request in the same cycle (zero-cycle grant path).
- Pointer update:
  - Two grants: rr_ptr ← (W1 + 1) mod NUM_CORES.
  - Only W0 granted: rr_ptr ← (W0 + 1) mod NUM_CORES.
  - No grant: rr_ptr unchanged.
- Latency: a request granted in cycle T gets rsp_valid[id] = 1 in cycle T+1.
  - Read: rsp_rdata slice = mem_rdata of the port used.
  - Write: rsp_rdata slice = 0.
- Each core receives at most one response per cycle.
  - A core may be granted again in T+1 while its T response is presented.
- Fairness: with all cores requesting continuously, every core is granted at least once every ceil(NUM_CORES/2) cycles, absent conflicts.
- Reset, while rst = 1:
  - rr_ptr = 0.
  - Pipeline valids = 0, so rsp_valid = 0 and rsp_rdata = 0.
  - req_ready = 0.
  - mem_we_a = mem_we_b = 0; addresses and wdata = 0.
- Reset mid-operation: in-flight responses are dropped. A write granted in the cycle rst rises is not issued.
- Addresses above MEM_SIZE alias on the low AW bits. This matches memory indexing and the conflict compare uses the same bits.

Test Plan:
- Single read: reset, mem word 5 = 0xDEADBEEF, core 2 reads addr 5 → req_ready[2] = 1 in T, mem_addr_a = 5, rsp_valid[2] = 1 with 0xDEADBEEF in T+1, no other rsp_valid.
- Dual grant: rr_ptr = 0, cores 1 and 3 read addr 10 and 20 → core 1 on port A, core 3 on port B, both responses in T+1, rr_ptr = 0 next.
- Write conflict: core 0 writes 0x11 to addr 7, core 1 reads addr 7, rr_ptr = 0 → only core 0 granted (port B idle, we_b = 0). Core 1 granted next cycle and reads 0x11.
- Round-robin: all 4 cores read distinct addresses continuously for 6 cycles → grant pairs (0,1), (2,3), (0,1)…, no core starved, each core gets 3 responses.
- Read/read same word: cores 2 and 3 read addr 9 → both granted in the same cycle, both receive identical data.
- Reset mid-op: grant core 1 read in T, assert rst in T+1 → rsp_valid = 0 in T+1, req_ready = 0, rr_ptr = 0 after release.
